rggen_bus_responder: RTL
========================

RGGEN_BUS_RESPONDER -- requirements
Module: rggen_bus_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8: byte address width of bus_if.address.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: data width in bits, power of two, at least 8.
REQ-003 SHALL have parameter WORDS, default 16: number of BUS_WIDTH storage words, at least 1.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0: wait cycles inserted before ready, range 0..15.
REQ-005 SHALL have parameter INITIAL_VALUE, default '0: reset value of every storage word, BUS_WIDTH bits.
REQ-006 SHALL have parameter READ_ONLY_MASK, default '0: WORDS bits; bit k set makes word k read-only.
REQ-007 SHALL have port i_clk, input, 1: sole clock; all state updates on rising edge.
REQ-008 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port bus_if, rggen_bus_if.slave: the responder end of the bus driven by a register-block bus master.
REQ-010 SHALL have port bus_if.valid, input, 1: request present.
REQ-011 SHALL have port bus_if.access, input, 2: 2'b10 READ, 2'b11 WRITE, 2'b01 POSTED_WRITE; bit0 = write.
REQ-012 SHALL have port bus_if.address, input, ADDRESS_WIDTH: byte address.
REQ-013 SHALL have ports bus_if.write_data (input, BUS_WIDTH) and bus_if.strobe (input, BUS_WIDTH/8): write data and byte enables.
REQ-014 SHALL have port bus_if.ready, output, 1: one-cycle response pulse.
REQ-015 SHALL have ports bus_if.status (output, 2: 0 OKAY, 2 SLAVE_ERROR, 3 DECODE_ERROR) and bus_if.read_data (output, BUS_WIDTH).
REQ-016 SHALL have port o_busy, output, 1: high while a request is held (states WAIT and RESP).

Function
REQ-017 SHALL implement states IDLE, WAIT and RESP, with all outputs driven from registers.
REQ-018 In IDLE with valid=1, SHALL latch access, address, write_data and strobe, then go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-019 In WAIT, SHALL decrement a counter loaded with WAIT_CYCLES-1 and go to RESP when the counter is 0.
REQ-020 In RESP, SHALL drive ready=1 for exactly one cycle, then return to IDLE.
REQ-021 Latency SHALL be: request accepted at edge N gives ready high during cycle N+1+WAIT_CYCLES.
REQ-022 Bus inputs SHALL be ignored outside IDLE; a new request is accepted no earlier than the cycle after ready.
REQ-023 Word index SHALL be address[ADDRESS_WIDTH-1:log2(BUS_WIDTH/8)]; low address bits SHALL be ignored.
REQ-024 Index >= WORDS SHALL give status 3 with read_data 0 and no storage change.
REQ-025 A write or posted write to a READ_ONLY_MASK word SHALL give status 2 with no storage change.
REQ-026 Any other access SHALL give status 0.
REQ-027 A write SHALL update only bytes whose strobe bit is 1, at the edge closing the RESP cycle.
REQ-028 Strobe all zero SHALL leave storage unchanged with status 0.
REQ-029 Posted write and write SHALL behave identically.
REQ-030 A read SHALL return the word value at acceptance time.
REQ-031 A read accepted after a write's ready cycle SHALL return the written data.
REQ-032 read_data SHALL be 0 for writes and whenever ready=0.
REQ-033 status SHALL be 0 whenever ready=0.

Reset
REQ-034 With i_rst=1 at an edge, SHALL go to IDLE, clear the wait counter and set ready=0, status=0, read_data=0, o_busy=0.
REQ-035 With i_rst=1 at an edge, every storage word SHALL be set to INITIAL_VALUE.
REQ-036 Reset asserted in WAIT or RESP SHALL abort the request: no ready pulse and no storage write.

Verification
REQ-037 Defaults: WRITE addr 0x04, data 0xDEADBEEF, strobe 4'hF accepted at edge N -> ready=1, status=0 in cycle N+1; then READ addr 0x04 -> read_data 0xDEADBEEF.
REQ-038 Partial strobe: word 2 = 0x11223344, WRITE 0xAABBCCDD with strobe 4'b0101 -> read returns 0x11BB33DD.
REQ-039 WAIT_CYCLES=3: READ accepted at edge N -> o_busy high, ready low in cycles N+1..N+3, ready high in N+4 only.
REQ-040 WORDS=16: READ addr 0x40 -> status 3, read_data 0; READ_ONLY_MASK bit1 set: WRITE addr 0x04 -> status 2 and word 1 unchanged.
REQ-041 WAIT_CYCLES=2: i_rst pulsed the cycle after accepting WRITE 0x12345678 to word 0 -> no ready pulse; word 0 reads INITIAL_VALUE.
REQ-042 Back-to-back: valid held with new requests -> ready pulses spaced 2+WAIT_CYCLES cycles apart; bus changes during WAIT do not alter the response.

Source files
------------

// File: rtl/rggen_bus_responder_if.sv
// Register-block bus between a bus master and a responder.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                       valid;
    logic [1:0]                 access;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [BUS_WIDTH-1:0]       write_data;
    logic [BUS_WIDTH/8-1:0]     strobe;
    logic                       ready;
    logic [1:0]                 status;
    logic [BUS_WIDTH-1:0]       read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_bus_responder.sv
// Register-file bus responder: fixed-latency handshake, byte-strobed storage,
// read-only words and decode errors for out-of-range addresses.
module rggen_bus_responder #(
    parameter int                   ADDRESS_WIDTH  = 8,
    parameter int                   BUS_WIDTH      = 32,
    parameter int                   WORDS          = 16,
    parameter int                   WAIT_CYCLES    = 0,
    parameter logic [BUS_WIDTH-1:0] INITIAL_VALUE  = '0,
    parameter logic [WORDS-1:0]     READ_ONLY_MASK = '0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    rggen_bus_if.slave bus_if,
    output logic       o_busy
);
    localparam int BYTES = BUS_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = ADDRESS_WIDTH - LSB;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef struct packed {
        logic                 write;
        logic [IDX_W-1:0]     index;
        logic [BUS_WIDTH-1:0] write_data;
        logic [BYTES-1:0]     strobe;
    } req_t;

    state_e                          state, state_n;
    logic [3:0]                      wait_cnt, wait_cnt_n;
    req_t                            req_q, bus_req, eff_req;
    logic [WORDS-1:0][BUS_WIDTH-1:0] mem;
    logic [WORDS-1:0]                word_hit;
    logic [31:0]                     idx32;
    logic                            in_range, read_only, mem_we;
    logic [BUS_WIDTH-1:0]            rd_word, rdata_c;
    logic [1:0]                      status_c;
    logic                            ready_q, busy_q;
    logic [1:0]                      status_q;
    logic [BUS_WIDTH-1:0]            rdata_q;

    // Low address bits and access[1] carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{bus_if.access[1], bus_if.address};

    assign bus_req = '{
        write:      bus_if.access[0],
        index:      bus_if.address[ADDRESS_WIDTH-1:LSB],
        write_data: bus_if.write_data,
        strobe:     bus_if.strobe
    };

    // Decode the live bus while idle, the held request otherwise; storage
    // cannot change between acceptance and the response cycle.
    always_comb begin
        eff_req   = (state == IDLE) ? bus_req : req_q;
        idx32     = 32'(eff_req.index);
        in_range  = idx32 < 32'(WORDS);
        word_hit  = '0;
        rd_word   = '0;
        for (int k = 0; k < WORDS; k++) begin
            word_hit[k] = in_range && (idx32 == 32'(k));
            if (word_hit[k]) rd_word = mem[k];
        end
        read_only = |(word_hit & READ_ONLY_MASK);
        if (!in_range)                       status_c = 2'd3;
        else if (eff_req.write && read_only) status_c = 2'd2;
        else                                 status_c = 2'd0;
        rdata_c   = (!eff_req.write && in_range) ? rd_word : '0;
        mem_we    = (state == RESP) && req_q.write && in_range && !read_only;
    end

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        case (state)
            IDLE: if (bus_if.valid) begin
                if (WAIT_CYCLES > 0) begin
                    state_n    = WAIT;
                    wait_cnt_n = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
                end else begin
                    state_n = RESP;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) state_n = RESP;
                else                  wait_cnt_n = wait_cnt - 4'd1;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            req_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            status_q <= '0;
            rdata_q  <= '0;
            mem      <= {WORDS{INITIAL_VALUE}};
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            if (state == IDLE && bus_if.valid) req_q <= bus_req;
            ready_q  <= (state_n == RESP);
            busy_q   <= (state_n != IDLE);
            status_q <= (state_n == RESP) ? status_c : 2'd0;
            rdata_q  <= (state_n == RESP) ? rdata_c  : '0;
            for (int w = 0; w < WORDS; w++)
                for (int b = 0; b < BYTES; b++)
                    if (mem_we && word_hit[w] && req_q.strobe[b])
                        mem[w][b*8 +: 8] <= req_q.write_data[b*8 +: 8];
        end
    end

    assign bus_if.ready     = ready_q;
    assign bus_if.status    = status_q;
    assign bus_if.read_data = rdata_q;
    assign o_busy           = busy_q;
endmodule
